ev_sequencer: RTL and testbench

//  Event-stream transmitter: replays a table of {event code, tick} entries onto an 8-bit evChar/evCharIsK

---
 rtl/ev_sequencer_if.sv | 36 +++
 rtl/ev_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_ev_sequencer.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ev_sequencer_if.sv
// Host-side bundle for the event sequencer: table write port, control/status word and the
// outgoing character stream.
interface ev_sequencer_if #(
    parameter int ADDR_WIDTH = 10
);
    logic                  tableWriteStrobe;
    logic [ADDR_WIDTH-1:0] tableWriteAddress;
    logic [39:0]           tableWriteData;
    logic                  csrStrobe;
    logic [31:0]           csrWriteData;
    logic [31:0]           csrReadData;
    logic [7:0]            evChar;
    logic                  evCharIsK;

    modport master (
        output tableWriteStrobe,
        output tableWriteAddress,
        output tableWriteData,
        output csrStrobe,
        output csrWriteData,
        input  csrReadData,
        input  evChar,
        input  evCharIsK
    );

    modport slave (
        input  tableWriteStrobe,
        input  tableWriteAddress,
        input  tableWriteData,
        input  csrStrobe,
        input  csrWriteData,
        output csrReadData,
        output evChar,
        output evCharIsK
    );
endinterface

// File: rtl/ev_sequencer.sv
// Event-stream transmitter: replays {event, tick} table entries onto an 8-bit char/K stream at
// programmed tick offsets from a start command, one-shot or looping. K28.5 fills idle cycles.
//
// state | meaning
// IDLE  | stopped, idle characters only
// FETCH | table address = index, read in flight
// LOAD  | entry on the RAM output; emit now (on time or late) or go wait
// WAIT  | hold captured entry until tick counter reaches its tick
// DONE  | one-shot table exhausted, idle characters, done flag set
module ev_sequencer #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic          evClk,
    input  logic          evReset,
    ev_sequencer_if.slave bus
);
    localparam int         DEPTH = 1 << ADDR_WIDTH;
    localparam logic [7:0] K28_5 = 8'hBC;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_WAIT,
        S_DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [39:0]           table_mem [DEPTH];
    logic [39:0]           rd_data;

    logic [ADDR_WIDTH-1:0] index;
    logic [ADDR_WIDTH-1:0] last_index;
    logic                  loop_en;
    logic                  running;
    logic [7:0]            late_count;
    logic [31:0]           tick_counter;
    logic [7:0]            held_evt;
    logic [31:0]           held_tick;
    logic [7:0]            ev_char_q;
    logic                  ev_k_q;

    logic                  start_cmd;
    logic                  stop_cmd;
    logic                  active;
    logic                  at_last;
    logic [7:0]            cur_evt;
    logic [31:0]           cur_tick;
    logic                  emit;
    logic                  late;
    logic                  wrap;
    logic [7:0]            ev_char_nxt;
    logic                  ev_k_nxt;
    logic                  unused_csr_bits;

    assign start_cmd = bus.csrStrobe & bus.csrWriteData[31];
    assign stop_cmd  = bus.csrStrobe & ~bus.csrWriteData[31];
    assign active    = (state == S_FETCH) || (state == S_LOAD) || (state == S_WAIT);
    assign at_last   = (index == last_index);

    // In LOAD the entry comes straight off the RAM; WAIT works from the captured copy.
    assign cur_evt  = (state == S_LOAD) ? rd_data[39:32] : held_evt;
    assign cur_tick = (state == S_LOAD) ? rd_data[31:0]  : held_tick;

    assign unused_csr_bits = ^bus.csrWriteData[29:ADDR_WIDTH];

    // Table RAM: registered read, write-before-nothing (same address read sees old data).
    always_ff @(posedge evClk) begin
        if (bus.tableWriteStrobe) begin
            table_mem[bus.tableWriteAddress] <= bus.tableWriteData;
        end
        rd_data <= table_mem[index];
    end

    always_ff @(posedge evClk) begin
        if (evReset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (start_cmd) begin
            state_nxt = S_FETCH;
        end else if (stop_cmd) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_FETCH: state_nxt = S_LOAD;
                S_LOAD, S_WAIT: begin
                    if (!emit) begin
                        state_nxt = S_WAIT;
                    end else if (at_last && !loop_en) begin
                        state_nxt = S_DONE;
                    end else begin
                        state_nxt = S_FETCH;
                    end
                end
                default: state_nxt = state;
            endcase
        end
    end

    // A control strobe always wins over an emit falling in the same cycle.
    always_comb begin
        emit        = 1'b0;
        late        = 1'b0;
        ev_char_nxt = K28_5;
        ev_k_nxt    = 1'b1;
        if (!bus.csrStrobe) begin
            if (state == S_LOAD) begin
                emit = (cur_tick <= tick_counter);
                late = (cur_tick < tick_counter);
            end else if (state == S_WAIT) begin
                emit = (cur_tick == tick_counter);
            end
        end
        wrap = emit && at_last && loop_en;
        if (emit && (cur_evt != 8'd0)) begin
            ev_char_nxt = cur_evt;
            ev_k_nxt    = 1'b0;
        end
    end

    always_ff @(posedge evClk) begin
        if (evReset) begin
            index        <= '0;
            last_index   <= '0;
            loop_en      <= 1'b0;
            running      <= 1'b0;
            late_count   <= 8'd0;
            tick_counter <= 32'd0;
            held_evt     <= 8'd0;
            held_tick    <= 32'd0;
            ev_char_q    <= K28_5;
            ev_k_q       <= 1'b1;
        end else begin
            ev_char_q <= ev_char_nxt;
            ev_k_q    <= ev_k_nxt;

            if (bus.csrStrobe) begin
                running    <= bus.csrWriteData[31];
                loop_en    <= bus.csrWriteData[30];
                last_index <= bus.csrWriteData[ADDR_WIDTH-1:0];
            end

            if (start_cmd) begin
                index        <= '0;
                late_count   <= 8'd0;
                tick_counter <= 32'd0;
            end else begin
                if (active && !stop_cmd) begin
                    tick_counter <= wrap ? 32'd0 : tick_counter + 32'd1;
                end
                if (emit) begin
                    if (!at_last) begin
                        index <= index + ADDR_WIDTH'(1);
                    end else if (loop_en) begin
                        index <= '0;
                    end
                end
                if (late && (late_count != 8'hFF)) begin
                    late_count <= late_count + 8'd1;
                end
            end

            if (state == S_LOAD) begin
                held_evt  <= rd_data[39:32];
                held_tick <= rd_data[31:0];
            end
        end
    end

    assign bus.evChar    = ev_char_q;
    assign bus.evCharIsK = ev_k_q;

    // {running, loop, done, 0, addrWidth[3:0], lateCount[7:0], index[15:0]}
    assign bus.csrReadData = {running, loop_en, (state == S_DONE), 1'b0,
                              4'(ADDR_WIDTH), late_count, 16'(index)};
endmodule

// File: tb/tb_ev_sequencer.sv
// Scoreboard bench for ev_sequencer: a timing model turns each table into expected
// (cycle, character) pairs; a negedge monitor pops and compares every data character.
module tb_ev_sequencer;
    localparam int AW = 10;

    typedef struct {
        logic [7:0] evt;
        int         tick;
    } entry_t;

    typedef struct {
        int         cyc;
        logic [7:0] ch;
    } exp_t;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    int     cyc = 0;
    int     tests = 0;
    int     fails = 0;
    entry_t tbl[$];
    exp_t   sb[$];
    exp_t   mon_e;

    ev_sequencer_if #(.ADDR_WIDTH(AW)) bus ();

    ev_sequencer #(.ADDR_WIDTH(AW)) dut (
        .evClk  (clk),
        .evReset(rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    always @(negedge clk) begin
        if (cyc >= 2) begin
            tests++;
            if (bus.evCharIsK === 1'b0) begin
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_event: got %02h at cycle %0d, nothing expected",
                             bus.evChar, cyc);
                end else begin
                    mon_e = sb.pop_front();
                    if (mon_e.cyc != cyc || bus.evChar !== mon_e.ch) begin
                        fails++;
                        $display("FAIL event: got %02h at cycle %0d, expected %02h at cycle %0d",
                                 bus.evChar, cyc, mon_e.ch, mon_e.cyc);
                    end
                end
            end else if (bus.evCharIsK !== 1'b1 || bus.evChar !== 8'hBC) begin
                fails++;
                $display("FAIL idle_char: got char %02h k %b at cycle %0d, expected BC k 1",
                         bus.evChar, bus.evCharIsK, cyc);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic step_to(input int target);
        int guard;
        guard = 0;
        while (cyc < target && guard < 20000) begin
            step();
            guard++;
        end
    endtask

    task automatic load_table();
        foreach (tbl[i]) begin
            bus.tableWriteStrobe  = 1'b1;
            bus.tableWriteAddress = AW'(i);
            bus.tableWriteData    = {tbl[i].evt, 32'(tbl[i].tick)};
            step();
        end
        bus.tableWriteStrobe = 1'b0;
    endtask

    task automatic csr_write(input bit run, input bit lp, input int last);
        bus.csrStrobe    = 1'b1;
        bus.csrWriteData = {run, lp, 30'(last)};
        step();
        bus.csrStrobe = 1'b0;
    endtask

    // Timing rules: counter is 0 the cycle after the start strobe; an entry can be looked at
    // no earlier than counter value r (1 for the first entry, previous emit + 2 afterwards);
    // it goes out at counter max(tick, r), one cycle later on the wire. Loops restart the
    // counter right after the last entry's emit. Nothing is expected past 'limit'.
    task automatic model(input int s, input bit lp, input int limit,
                         output int late, output int last_out);
        int base;
        int r;
        int e;
        int i;
        int n;
        exp_t x;
        base     = s + 1;
        r        = 1;
        i        = 0;
        late     = 0;
        last_out = s;
        n        = tbl.size();
        for (int g = 0; g < 2000; g++) begin
            e = (tbl[i].tick > r) ? tbl[i].tick : r;
            if (base + e + 1 > limit) break;
            if (tbl[i].tick < r && late < 255) late++;
            if (tbl[i].evt != 8'd0) begin
                x.cyc = base + e + 1;
                x.ch  = tbl[i].evt;
                sb.push_back(x);
            end
            last_out = base + e + 1;
            r = e + 2;
            if (i == n - 1) begin
                if (!lp) break;
                base = base + e + 1;
                r    = 1;
                i    = 0;
            end else begin
                i++;
            end
        end
    endtask

    task automatic add_entry(input logic [7:0] evt, input int tick);
        entry_t en;
        en.evt  = evt;
        en.tick = tick;
        tbl.push_back(en);
    endtask

    task automatic run_oneshot(input string name);
        int s;
        int late;
        int lo;
        load_table();
        s = cyc;
        model(s, 1'b0, 1 << 30, late, lo);
        csr_write(1'b1, 1'b0, tbl.size() - 1);
        step_to(lo + 4);
        check({name, "_drain"}, 32'(sb.size()), 32'd0);
        check({name, "_csr"}, bus.csrReadData,
              {1'b1, 1'b0, 1'b1, 1'b0, 4'hA, 8'(late), 16'(tbl.size() - 1)});
        sb.delete();
    endtask

    task automatic run_stopped(input string name, input bit lp, input int stop_off);
        int s;
        int late;
        int lo;
        load_table();
        s = cyc;
        model(s, lp, s + stop_off, late, lo);
        csr_write(1'b1, lp, tbl.size() - 1);
        step_to(s + stop_off);
        csr_write(1'b0, lp, tbl.size() - 1);
        step_to(cyc + 5);
        check({name, "_drain"}, 32'(sb.size()), 32'd0);
        check({name, "_csr"}, bus.csrReadData & 32'hFFFF_0000,
              {1'b0, lp, 1'b0, 1'b0, 4'hA, 8'(late), 16'h0000});
        sb.delete();
    endtask

    initial begin
        int s;
        int late;
        int lo;
        int n;
        int tk;
        logic [7:0] ev;

        bus.tableWriteStrobe  = 1'b0;
        bus.tableWriteAddress = '0;
        bus.tableWriteData    = '0;
        bus.csrStrobe         = 1'b0;
        bus.csrWriteData      = '0;
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        check("reset_csr", bus.csrReadData, 32'h0A00_0000);
        check("reset_char", {23'd0, bus.evCharIsK, bus.evChar}, {23'd0, 1'b1, 8'hBC});

        tbl.delete();
        add_entry(8'h10, 5); add_entry(8'h20, 9); add_entry(8'h30, 20);
        run_oneshot("basic");

        tbl.delete();
        add_entry(8'h10, 5); add_entry(8'h11, 6);
        run_oneshot("late_spacing");

        tbl.delete();
        add_entry(8'h10, 0);
        run_oneshot("late_first");

        tbl.delete();
        add_entry(8'h40, 3); add_entry(8'h41, 7);
        run_stopped("loop", 1'b1, 26);

        tbl.delete();
        add_entry(8'h50, 2); add_entry(8'h00, 10);
        run_stopped("padding", 1'b1, 30);

        tbl.delete();
        add_entry(8'h10, 5); add_entry(8'h20, 9); add_entry(8'h30, 20);
        run_stopped("stop_mid", 1'b0, 6);
        run_oneshot("restart");

        tbl.delete();
        add_entry(8'h60, 50);
        load_table();
        s = cyc;
        model(s, 1'b0, s + 10, late, lo);
        csr_write(1'b1, 1'b0, 0);
        step_to(s + 10);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("reset_wait_csr", bus.csrReadData, 32'h0A00_0000);
        check("reset_wait_char", {23'd0, bus.evCharIsK, bus.evChar}, {23'd0, 1'b1, 8'hBC});
        step_to(cyc + 3);
        check("reset_wait_drain", 32'(sb.size()), 32'd0);
        sb.delete();

        tbl.delete();
        add_entry(8'h70, 1); add_entry(8'h71, 3); add_entry(8'h72, 4);
        run_oneshot("after_reset");

        for (int t = 0; t < 24; t++) begin
            tbl.delete();
            n  = $urandom_range(1, 6);
            tk = $urandom_range(0, 4);
            for (int i = 0; i < n; i++) begin
                ev = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
                add_entry(ev, tk);
                tk = tk + $urandom_range(0, 6);
            end
            if (t % 3 == 2) begin
                run_stopped("rand_loop", 1'b1, $urandom_range(20, 70));
            end else if (t % 5 == 4) begin
                run_stopped("rand_stop", 1'b0, $urandom_range(3, 20));
            end else begin
                run_oneshot("rand_oneshot");
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
